// File: rtl/key_event_ctrl_if.sv
//============================================================================
// key_event_ctrl_if: PIO Avalon-MM master bus plus event valid/ready stream.
// Rev 1.0
//============================================================================
`default_nettype none

interface key_event_ctrl_if;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        pio_irq;
    logic        evt_valid;
    logic [1:0]  evt_key;
    logic        evt_ready;

    modport master (
        output pio_address, pio_chipselect, pio_write_n, pio_writedata,
        output evt_valid, evt_key,
        input  pio_readdata, pio_irq, evt_ready
    );

    modport slave (
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
        input  evt_valid, evt_key,
        output pio_readdata, pio_irq, evt_ready
    );
endinterface

`default_nettype wire

// File: rtl/key_event_ctrl.sv
//============================================================================
// key_event_ctrl: services the key edge-capture PIO and queues key events.
// Rev 1.0
//============================================================================
`default_nettype none

module key_event_ctrl #(
    parameter int         FIFO_DEPTH   = 8,
    parameter int         READ_LATENCY = 1,
    parameter logic [2:0] INIT_MASK    = 3'b111
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    key_event_ctrl_if.master bus,
    input  wire logic [2:0]  mask_cfg,
    input  wire logic        mask_update,
    output logic             evt_overflow,
    input  wire logic        overflow_clr,
    output logic             busy
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_WR_MASK = 3'd1,
        S_IDLE    = 3'd2,
        S_RD_CAP  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_CLR     = 3'd5,
        S_PUSH    = 3'd6
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  mask, mask_nx;
    logic [2:0]  pend_mask, pend_mask_nx;
    logic        pend, pend_nx;
    logic [2:0]  cap, cap_nx;
    logic [1:0]  wait_cnt, wait_cnt_nx;
    logic        push;
    logic [1:0]  push_key;

    logic        cs_nx, wn_nx;
    logic [1:0]  addr_nx;
    logic [31:0] wd_nx;

    logic [1:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_ok, drop;

    logic        unused_rd;
    assign unused_rd = ^bus.pio_readdata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_INIT;
            mask      <= INIT_MASK;
            pend_mask <= 3'b000;
            pend      <= 1'b0;
            cap       <= 3'b000;
            wait_cnt  <= 2'd0;
        end else begin
            state     <= state_nx;
            mask      <= mask_nx;
            pend_mask <= pend_mask_nx;
            pend      <= pend_nx;
            cap       <= cap_nx;
            wait_cnt  <= wait_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        mask_nx      = mask;
        pend_mask_nx = pend_mask;
        pend_nx      = pend;
        cap_nx       = cap;
        wait_cnt_nx  = wait_cnt;
        push         = 1'b0;
        push_key     = cap[0] ? 2'd0 : (cap[1] ? 2'd1 : 2'd2);

        if (state != S_IDLE && mask_update) begin
            pend_nx      = 1'b1;
            pend_mask_nx = mask_cfg;
        end

        case (state)
            S_INIT:    state_nx = S_WR_MASK;
            S_WR_MASK: state_nx = S_IDLE;
            S_IDLE: begin
                if (pend || mask_update) begin
                    mask_nx  = mask_update ? mask_cfg : pend_mask;
                    pend_nx  = 1'b0;
                    state_nx = S_WR_MASK;
                end else if (bus.pio_irq) begin
                    state_nx = S_RD_CAP;
                end
            end
            S_RD_CAP: begin
                wait_cnt_nx = 2'd0;
                state_nx    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_cnt == LAT_LAST) begin
                    cap_nx   = bus.pio_readdata[2:0] & mask;
                    state_nx = S_CLR;
                end else begin
                    wait_cnt_nx = wait_cnt + 2'd1;
                end
            end
            S_CLR:     state_nx = (cap == 3'b000) ? S_IDLE : S_PUSH;
            S_PUSH: begin
                push   = 1'b1;
                // cap & (cap-1) drops the lowest set bit, the one being pushed
                cap_nx = cap & (cap - 3'd1);
                if (cap_nx == 3'b000)
                    state_nx = S_IDLE;
            end
            default:   state_nx = S_INIT;
        endcase

        // Bus outputs are registered, so they are derived from the state being entered
        cs_nx   = (state_nx == S_WR_MASK) || (state_nx == S_RD_CAP) || (state_nx == S_CLR);
        wn_nx   = !((state_nx == S_WR_MASK) || (state_nx == S_CLR));
        addr_nx = (state_nx == S_WR_MASK) ? 2'd2 :
                  ((state_nx == S_RD_CAP) || (state_nx == S_CLR)) ? 2'd3 : 2'd0;
        wd_nx   = (state_nx == S_WR_MASK) ? {29'b0, mask_nx} : 32'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.pio_chipselect <= 1'b0;
            bus.pio_write_n    <= 1'b1;
            bus.pio_address    <= 2'd0;
            bus.pio_writedata  <= 32'h0;
        end else begin
            bus.pio_chipselect <= cs_nx;
            bus.pio_write_n    <= wn_nx;
            bus.pio_address    <= addr_nx;
            bus.pio_writedata  <= wd_nx;
        end
    end

    assign busy = (state != S_IDLE);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && bus.evt_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= push_key;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                evt_overflow <= 1'b1;
            else if (overflow_clr)
                evt_overflow <= 1'b0;
        end
    end

    assign bus.evt_valid = !empty;
    assign bus.evt_key   = empty ? 2'd0 : mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
//============================================================================
// tb_key_event_ctrl: PIO edge-capture model with access/event scoreboard.
// Rev 1.0
//============================================================================
`default_nettype none

module tb_key_event_ctrl;
    localparam int FIFO_DEPTH   = 2;
    localparam int READ_LATENCY = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] mask_cfg;
    logic       mask_update;
    logic       evt_overflow;
    logic       overflow_clr;
    logic       busy;

    key_event_ctrl_if bus ();

    key_event_ctrl #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .READ_LATENCY(READ_LATENCY),
        .INIT_MASK   (3'b111)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .mask_cfg    (mask_cfg),
        .mask_update (mask_update),
        .evt_overflow(evt_overflow),
        .overflow_clr(overflow_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // PIO model: edge capture, irq mask, pipelined read data
    logic [2:0]  in_port  = 3'b000;
    logic [2:0]  in_prev  = 3'b000;
    logic [2:0]  edge_cap = 3'b000;
    logic [2:0]  pio_mask = 3'b000;
    logic [31:0] rd_pipe [READ_LATENCY];

    initial for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] = 32'h0;

    always @(posedge clk) begin
        in_prev <= in_port;
        if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == 2'd3)
            edge_cap <= 3'b000;
        else
            edge_cap <= edge_cap | (in_port & ~in_prev);
        if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == 2'd2)
            pio_mask <= bus.pio_writedata[2:0];
        rd_pipe[0] <= (bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd3)
                      ? {29'b0, edge_cap} : 32'h0;
        for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bus.pio_readdata = rd_pipe[READ_LATENCY-1];
    assign bus.pio_irq      = |(edge_cap & pio_mask);

    // Scoreboard: {is_write, address, writedata} per access, key per event
    typedef logic [34:0] acc_t;
    localparam acc_t ACC_RD  = {1'b1 ^ 1'b1, 2'd3, 32'h0};
    localparam acc_t ACC_CLR = {1'b1, 2'd3, 32'h0};

    acc_t       exp_acc[$];
    logic [1:0] exp_evt[$];
    acc_t       got_acc, want_acc;
    logic [1:0] want_evt;
    int         n_cmp = 0;
    int         n_err = 0;

    always @(negedge clk) begin
        if (bus.pio_chipselect) begin
            got_acc = {~bus.pio_write_n, bus.pio_address, bus.pio_writedata};
            n_cmp++;
            assert (exp_acc.size() != 0) else begin
                n_err++;
                $error("FAIL acc_unexpected: observed %h expected none", got_acc);
            end
            if (exp_acc.size() != 0) begin
                want_acc = exp_acc.pop_front();
                n_cmp++;
                assert (got_acc === want_acc) else begin
                    n_err++;
                    $error("FAIL acc: observed %h expected %h", got_acc, want_acc);
                end
            end
        end
        if (bus.evt_valid && bus.evt_ready) begin
            n_cmp++;
            assert (exp_evt.size() != 0) else begin
                n_err++;
                $error("FAIL evt_unexpected: observed %0d expected none", bus.evt_key);
            end
            if (exp_evt.size() != 0) begin
                want_evt = exp_evt.pop_front();
                n_cmp++;
                assert (bus.evt_key === want_evt) else begin
                    n_err++;
                    $error("FAIL evt_key: observed %0d expected %0d", bus.evt_key, want_evt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a PIO access at address 3 of the given direction
    task automatic wait_acc(input string tag, input logic wn);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = bus.pio_chipselect && (bus.pio_write_n == wn) && (bus.pio_address == 2'd3);
        end
        n_cmp++;
        assert (found) else begin
            n_err++;
            $error("FAIL %s: observed timeout expected access", tag);
        end
    endtask

    task automatic settle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            done = !busy && !bus.pio_irq;
        end
        n_cmp++;
        assert (done) else begin
            n_err++;
            $error("FAIL %s: observed busy expected idle", tag);
        end
        tick();
        tick();
    endtask

    task automatic press(input logic [2:0] keys, input bit serviced);
        in_port = keys;
        if (serviced) begin
            exp_acc.push_back(ACC_RD);
            exp_acc.push_back(ACC_CLR);
        end
        tick();
        in_port = 3'b000;
    endtask

    initial begin : stim
        reset_n      = 1'b0;
        mask_cfg     = 3'b000;
        mask_update  = 1'b0;
        overflow_clr = 1'b0;
        bus.evt_ready = 1'b1;
        repeat (3) tick();

        chk("rst_cs", bus.pio_chipselect, 0);
        chk("rst_wn", bus.pio_write_n, 1);
        chk("rst_addr", bus.pio_address, 0);
        chk("rst_wd", bus.pio_writedata, 0);
        chk("rst_valid", bus.evt_valid, 0);
        chk("rst_key", bus.evt_key, 0);
        chk("rst_ovf", evt_overflow, 0);

        // Initial mask write one cycle after release
        exp_acc.push_back({1'b1, 2'd2, 32'd7});
        @(negedge clk) reset_n = 1'b1;
        tick();
        chk("init_cs", bus.pio_chipselect, 1);
        chk("init_addr", bus.pio_address, 2);
        chk("init_wd", bus.pio_writedata, 7);
        tick();
        chk("init_idle", busy, 0);

        // Single key 1: read, one wait cycle, clear
        exp_evt.push_back(2'd1);
        press(3'b010, 1'b1);
        wait_acc("k1_rd", 1'b1);
        tick();
        chk("k1_wait_cs", bus.pio_chipselect, 0);
        tick();
        chk("k1_clr_cs", bus.pio_chipselect, 1);
        chk("k1_clr_wn", bus.pio_write_n, 0);
        settle("k1_settle");
        chk("k1_edgecap", edge_cap, 0);

        // Keys 0 and 2 together: one pass, events on consecutive cycles
        exp_evt.push_back(2'd0);
        exp_evt.push_back(2'd2);
        press(3'b101, 1'b1);
        wait_acc("k02_clr", 1'b0);
        tick();
        tick();
        chk("k02_v0", bus.evt_valid, 1);
        chk("k02_key0", bus.evt_key, 0);
        tick();
        chk("k02_v1", bus.evt_valid, 1);
        chk("k02_key2", bus.evt_key, 2);
        settle("k02_settle");

        // Overflow with a stalled consumer
        bus.evt_ready = 1'b0;
        exp_evt.push_back(2'd0);
        press(3'b001, 1'b1);
        settle("ovf_a");
        exp_evt.push_back(2'd1);
        press(3'b010, 1'b1);
        settle("ovf_b");
        chk("ovf_full_valid", bus.evt_valid, 1);
        chk("ovf_full_key", bus.evt_key, 0);
        chk("ovf_pre", evt_overflow, 0);
        press(3'b100, 1'b1);
        wait_acc("ovf_clr_acc", 1'b0);
        tick();
        tick();
        chk("ovf_set", evt_overflow, 1);
        settle("ovf_c");
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_cleared", evt_overflow, 0);
        overflow_clr = 1'b1;
        press(3'b001, 1'b1);
        wait_acc("ovf_hold_acc", 1'b0);
        tick();
        chk("ovf_hold_pre", evt_overflow, 0);
        tick();
        chk("ovf_set_wins", evt_overflow, 1);
        overflow_clr = 1'b0;
        tick();
        chk("ovf_sticky", evt_overflow, 1);
        chk("ovf_head_kept", bus.evt_key, 0);

        // Reset during CLR with events held in the FIFO
        in_port = 3'b100;
        exp_acc.push_back(ACC_RD);
        exp_acc.push_back({1'b1, 2'd2, 32'd7});
        exp_acc.push_back(ACC_RD);
        exp_acc.push_back(ACC_CLR);
        tick();
        in_port = 3'b000;
        wait_acc("rst_mid_clr", 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_cs", bus.pio_chipselect, 0);
        chk("rst_mid_valid", bus.evt_valid, 0);
        chk("rst_mid_ovf", evt_overflow, 0);
        exp_evt.delete();
        exp_evt.push_back(2'd2);
        bus.evt_ready = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        tick();
        chk("rst_re_cs", bus.pio_chipselect, 1);
        chk("rst_re_addr", bus.pio_address, 2);
        chk("rst_re_wd", bus.pio_writedata, 7);
        settle("rst_settle");

        // Mask update arriving during RD_WAIT is applied after the pass
        exp_evt.push_back(2'd1);
        press(3'b010, 1'b1);
        exp_acc.push_back({1'b1, 2'd2, 32'd2});
        wait_acc("mu_rd", 1'b1);
        tick();
        mask_cfg    = 3'b010;
        mask_update = 1'b1;
        tick();
        mask_update = 1'b0;
        settle("mu_settle");
        chk("mu_pio_mask", pio_mask, 2);
        press(3'b001, 1'b0);
        repeat (10) tick();
        chk("mu_no_evt", bus.evt_valid, 0);
        chk("mu_idle", busy, 0);

        chk("sb_acc_empty", exp_acc.size(), 0);
        chk("sb_evt_empty", exp_evt.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
